// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, decode handoff and redirect.
// fetchMisaligned exists only when FETCH_MISALIGN_TRAP_EN is defined.
interface fetch_unit_if;
  logic        imemReqValid;
  logic        imemReqReady;
  logic [31:0] imemAddr;
  logic        imemRespValid;
  logic [31:0] imemRespData;
  logic [31:0] instruction;
  logic        decodeEnable;
  logic [31:0] decodePc;
  logic        decodeReady;
  logic        redirectValid;
  logic [31:0] redirectTarget;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetchMisaligned;

  modport master (
    output imemReqValid, imemAddr, instruction, decodeEnable, decodePc, fetchMisaligned,
    input  imemReqReady, imemRespValid, imemRespData, decodeReady, redirectValid, redirectTarget
  );
  modport slave (
    input  imemReqValid, imemAddr, instruction, decodeEnable, decodePc, fetchMisaligned,
    output imemReqReady, imemRespValid, imemRespData, decodeReady, redirectValid, redirectTarget
  );
`else
  modport master (
    output imemReqValid, imemAddr, instruction, decodeEnable, decodePc,
    input  imemReqReady, imemRespValid, imemRespData, decodeReady, redirectValid, redirectTarget
  );
  modport slave (
    input  imemReqValid, imemAddr, instruction, decodeEnable, decodePc,
    output imemReqReady, imemRespValid, imemRespData, decodeReady, redirectValid, redirectTarget
  );
`endif
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited in-order fetch into a small buffer, with redirect squash.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirect targets halt fetch and raise fetchMisaligned.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input logic          clk,
  input logic          rstN,
  fetch_unit_if.master bus
);
  localparam int unsigned CW     = $clog2(DEPTH + 1);
  localparam int unsigned PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW:0] CREDIT = (CW + 1)'(DEPTH);

  logic [31:0]   fetch_pc, fetch_pc_nxt;
  logic [31:0]   resp_pc, resp_pc_nxt;
  logic [CW-1:0] count, count_nxt;
  logic [CW-1:0] outstanding, outstanding_nxt;
  logic [CW-1:0] drop_count, drop_count_nxt;
  logic [PW-1:0] rd_ptr, rd_ptr_nxt;
  logic [PW-1:0] wr_ptr, wr_ptr_nxt;
  logic [31:0]   buf_data [DEPTH];
  logic [31:0]   buf_pc   [DEPTH];
  logic          halted;
  logic          has_credit, req_fire, resp_fire, push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Buffer entries plus in-flight requests never exceed DEPTH, so every response has a slot.
  assign has_credit = ({1'b0, count} + {1'b0, outstanding}) < CREDIT;

  assign bus.imemReqValid = rstN && has_credit && !bus.redirectValid && !halted;
  assign bus.imemAddr     = fetch_pc;
  assign bus.decodeEnable = (count != '0);
  assign bus.instruction  = buf_data[rd_ptr];
  assign bus.decodePc     = buf_pc[rd_ptr];

  assign req_fire  = bus.imemReqValid && bus.imemReqReady;
  assign resp_fire = bus.imemRespValid;
  assign pop       = bus.decodeEnable && bus.decodeReady && !bus.redirectValid;
  assign push      = resp_fire && (drop_count == '0) && !bus.redirectValid && !halted;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic halted_nxt;

  always_comb begin
    halted_nxt = halted;
    if (bus.redirectValid && (bus.redirectTarget[1:0] != 2'b00)) halted_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) halted <= 1'b0;
    else       halted <= halted_nxt;
  end

  assign bus.fetchMisaligned = halted;
`else
  assign halted = 1'b0;
`endif

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latches).
    fetch_pc_nxt    = fetch_pc;
    resp_pc_nxt     = resp_pc;
    count_nxt       = count;
    outstanding_nxt = outstanding;
    drop_count_nxt  = drop_count;
    rd_ptr_nxt      = rd_ptr;
    wr_ptr_nxt      = wr_ptr;

    if (bus.redirectValid) begin
      // Everything still in flight after this edge belongs to the old path.
      fetch_pc_nxt    = bus.redirectTarget;
      resp_pc_nxt     = bus.redirectTarget;
      count_nxt       = '0;
      rd_ptr_nxt      = '0;
      wr_ptr_nxt      = '0;
      outstanding_nxt = outstanding - CW'(resp_fire);
      drop_count_nxt  = outstanding - CW'(resp_fire);
    end else begin
      if (req_fire) fetch_pc_nxt = fetch_pc + 32'd4;
      outstanding_nxt = outstanding + CW'(req_fire) - CW'(resp_fire);
      if (resp_fire && (drop_count != '0)) drop_count_nxt = drop_count - CW'(1);
      if (push) begin
        resp_pc_nxt = resp_pc + 32'd4;
        wr_ptr_nxt  = ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr_nxt = ptr_inc(rd_ptr);
      count_nxt = count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      drop_count  <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      // NOTE: the buffer is tiny and its head drives instruction/decodePc, so it is reset like any flop.
      for (int i = 0; i < int'(DEPTH); i++) begin
        buf_data[i] <= '0;
        buf_pc[i]   <= RESET_PC;
      end
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      fetch_pc    <= fetch_pc_nxt;
      resp_pc     <= resp_pc_nxt;
      count       <= count_nxt;
      outstanding <= outstanding_nxt;
      drop_count  <= drop_count_nxt;
      rd_ptr      <= rd_ptr_nxt;
      wr_ptr      <= wr_ptr_nxt;
      if (push) begin
        buf_data[wr_ptr] <= bus.imemRespData;
        buf_pc[wr_ptr]   <= resp_pc;
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order memory model plus sequential-PC decode-stream model.
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam logic [31:0] KEY      = 32'h1357_9BDF;

  logic clk  = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(2)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  typedef struct {
    int          due;
    logic [31:0] addr;
  } mem_req_t;

  mem_req_t    mq[$];
  logic [31:0] acc_log[$];
  logic [31:0] pop_log[$];

  int checks    = 0;
  int failures  = 0;
  int cyc       = 0;
  int lat       = 1;

  logic        want_rst       = 1'b0;
  logic        want_ready     = 1'b1;
  logic        want_mem_ready = 1'b1;
  logic        want_redir     = 1'b0;
  logic [31:0] want_target    = '0;

  logic [31:0] exp_fetch = RESET_PC;
  logic [31:0] exp_dec   = RESET_PC;

  logic        s_req, s_dec;
  logic [31:0] s_addr, s_instr, s_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        s_mis;
`endif

  function automatic logic [31:0] word_of(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'h0050_0093;
      32'h0000_0104: return 32'h0010_0113;
      default:       return a ^ KEY;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: drive inputs on the falling edge, sample just before the rising edge, update the model.
  task automatic step();
    @(negedge clk);
    cyc++;
    rstN = want_rst;
    if (!want_rst) mq.delete();
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      bus.imemRespValid = 1'b1;
      bus.imemRespData  = word_of(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      bus.imemRespValid = 1'b0;
      bus.imemRespData  = 32'hDEAD_BEEF;
    end
    bus.decodeReady    = want_ready;
    bus.imemReqReady   = want_mem_ready;
    bus.redirectValid  = want_redir;
    bus.redirectTarget = want_target;
    #4;
    s_req   = bus.imemReqValid;
    s_dec   = bus.decodeEnable;
    s_addr  = bus.imemAddr;
    s_instr = bus.instruction;
    s_pc    = bus.decodePc;
`ifdef FETCH_MISALIGN_TRAP_EN
    s_mis   = bus.fetchMisaligned;
`endif
    if (!rstN) begin
      check("reset_req_valid", 32'(s_req), 32'd0);
      check("reset_decode_enable", 32'(s_dec), 32'd0);
      exp_fetch = RESET_PC;
      exp_dec   = RESET_PC;
    end else begin
      if (s_dec) check("instr_matches_pc", s_instr, word_of(s_pc));
      if (want_redir) begin
        check("no_req_in_redirect", 32'(s_req), 32'd0);
        exp_fetch = want_target;
        exp_dec   = want_target;
      end else begin
        if (s_req && want_mem_ready) begin
          check("fetch_addr", s_addr, exp_fetch);
          exp_fetch = exp_fetch + 32'd4;
          acc_log.push_back(s_addr);
          mq.push_back('{cyc + lat, s_addr});
        end
        if (s_dec && want_ready) begin
          check("decode_pc", s_pc, exp_dec);
          exp_dec = exp_dec + 32'd4;
          pop_log.push_back(s_pc);
        end
      end
    end
  endtask

  task automatic do_reset();
    want_rst   = 1'b0;
    want_redir = 1'b0;
    step();
    step();
    check("reset_instruction", s_instr, 32'd0);
    check("reset_decode_pc", s_pc, RESET_PC);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("reset_misaligned", 32'(s_mis), 32'd0);
`endif
    want_rst = 1'b1;
    acc_log.delete();
    pop_log.delete();
  endtask

  task automatic redirect_step(input logic [31:0] target);
    want_redir  = 1'b1;
    want_target = target;
    step();
    want_redir  = 1'b0;
  endtask

  task automatic run_until(input int n_acc, input int n_pop, input int budget, input string name);
    int n;
    n = 0;
    while ((acc_log.size() < n_acc || pop_log.size() < n_pop) && n < budget) begin
      step();
      n++;
    end
    check(name, 32'(acc_log.size() >= n_acc && pop_log.size() >= n_pop), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.imemReqReady   = 1'b1;
    bus.imemRespValid  = 1'b0;
    bus.imemRespData   = '0;
    bus.decodeReady    = 1'b1;
    bus.redirectValid  = 1'b0;
    bus.redirectTarget = '0;

    // Boot with 1-cycle memory.
    lat = 1; want_ready = 1'b1; want_mem_ready = 1'b1;
    do_reset();
    step();
    check("boot_req_valid", 32'(s_req), 32'd1);
    check("boot_addr0", s_addr, 32'h0000_0100);
    check("boot_dec_idle0", 32'(s_dec), 32'd0);
    step();
    check("boot_addr1", s_addr, 32'h0000_0104);
    check("boot_dec_idle1", 32'(s_dec), 32'd0);
    step();
    check("boot_dec_first", 32'(s_dec), 32'd1);
    check("boot_pc0", s_pc, 32'h0000_0100);
    check("boot_word0", s_instr, 32'h0050_0093);
    step();
    check("boot_pc1", s_pc, 32'h0000_0104);
    check("boot_word1", s_instr, 32'h0010_0113);

    // Backpressure: decode stalled, credit caps fetch at two.
    do_reset();
    want_ready = 1'b0;
    repeat (6) step();
    check("bp_accepts", 32'(acc_log.size()), 32'd2);
    check("bp_req_idle", 32'(s_req), 32'd0);
    check("bp_head_pc", s_pc, 32'h0000_0100);
    want_ready = 1'b1;
    step();
    check("bp_drain0", s_pc, 32'h0000_0100);
    step();
    check("bp_drain1", s_pc, 32'h0000_0104);
    run_until(3, 2, 10, "bp_resume_timeout");
    if (acc_log.size() >= 3) check("bp_resume_addr", acc_log[2], 32'h0000_0108);

    // Redirect with two requests in flight, 3-cycle memory.
    lat = 3;
    do_reset();
    step();
    step();
    check("rd_in_flight", 32'(acc_log.size()), 32'd2);
    pop_log.delete();
    redirect_step(32'h0000_0200);
    step();
    check("rd_dec_cleared", 32'(s_dec), 32'd0);
    run_until(0, 1, 20, "rd_first_timeout");
    if (pop_log.size() >= 1) begin
      check("rd_first_pc", pop_log[0], 32'h0000_0200);
      check("rd_first_word", s_instr, 32'h1357_99DF);
    end

    // Redirect coinciding with a response and a pop.
    lat = 1;
    do_reset();
    step();
    step();
    redirect_step(32'h0000_0200);
    check("co_pop_pending", 32'(s_dec), 32'd1);
    check("co_pop_pc", s_pc, 32'h0000_0100);
    acc_log.delete();
    pop_log.delete();
    step();
    check("co_buffer_empty", 32'(s_dec), 32'd0);
    check("co_new_req", 32'(s_req), 32'd1);
    check("co_new_addr", s_addr, 32'h0000_0200);
    run_until(0, 2, 20, "co_stream_timeout");
    if (pop_log.size() >= 2) begin
      check("co_stream0", pop_log[0], 32'h0000_0200);
      check("co_stream1", pop_log[1], 32'h0000_0204);
    end

    // Address wrap-around.
    acc_log.delete();
    pop_log.delete();
    redirect_step(32'hFFFF_FFFC);
    run_until(2, 2, 20, "wrap_timeout");
    if (acc_log.size() >= 2 && pop_log.size() >= 2) begin
      check("wrap_addr0", acc_log[0], 32'hFFFF_FFFC);
      check("wrap_addr1", acc_log[1], 32'h0000_0000);
      check("wrap_pc0", pop_log[0], 32'hFFFF_FFFC);
      check("wrap_pc1", pop_log[1], 32'h0000_0000);
    end

    // Misaligned redirect target.
    do_reset();
    step();
    step();
    acc_log.delete();
    pop_log.delete();
    redirect_step(32'h0000_0202);
`ifdef FETCH_MISALIGN_TRAP_EN
    step();
    check("mis_flag", 32'(s_mis), 32'd1);
    check("mis_dec_empty", 32'(s_dec), 32'd0);
    for (int i = 0; i < 20; i++) begin
      step();
      check("mis_halt_req", 32'(s_req), 32'd0);
      check("mis_halt_dec", 32'(s_dec), 32'd0);
    end
    check("mis_flag_sticky", 32'(s_mis), 32'd1);
    do_reset();
    step();
    check("mis_restart_req", 32'(s_req), 32'd1);
    check("mis_restart_addr", s_addr, RESET_PC);
    check("mis_cleared", 32'(s_mis), 32'd0);
`else
    run_until(2, 2, 20, "mis_timeout");
    if (acc_log.size() >= 2 && pop_log.size() >= 2) begin
      check("mis_addr0", acc_log[0], 32'h0000_0202);
      check("mis_addr1", acc_log[1], 32'h0000_0206);
      check("mis_pc0", pop_log[0], 32'h0000_0202);
      check("mis_pc1", pop_log[1], 32'h0000_0206);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
